// File: rtl/sensor_conditioner.sv
// Sensor front-end: 2-flop sync, tick-based debounce, one-tick event stretch,
// refractory lockout and saturating per-channel event counters.
module sensor_conditioner #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned REFRACT_TICKS  = 50,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         sensor_raw,
  input  logic                      clear_counts,
  output logic [NUM_CH-1:0]         event_out,
  output logic [NUM_CH-1:0]         busy,
  output logic                      tick,
  output logic [NUM_CH*CNT_W-1:0]   event_cnt
);

  localparam int unsigned TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_MAX = (DEBOUNCE_TICKS > REFRACT_TICKS) ? DEBOUNCE_TICKS : REFRACT_TICKS;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0]    REF_LIM   = CW'(REFRACT_TICKS);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    FIRE    = 2'd2,
    REFRACT = 2'd3
  } state_e;

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_c;
  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] event_q, event_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  evt_q   [NUM_CH];
  logic [CNT_W-1:0]  evt_d   [NUM_CH];

  assign tick_c = (tick_cnt_q == TICK_LAST);

  // Tick divider and synchroniser next-state
  always_comb begin
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
    sync1_d    = sensor_raw;
    sync2_d    = sync1_q;
  end

  // Per-channel FSM, counter and registered-output next-state
  always_comb begin
    event_d = '0;
    busy_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      evt_d[i]   = evt_q[i];
      if (tick_c) begin
        unique case (state_q[i])
          IDLE: begin
            if (sync2_q[i]) begin
              if (DEBOUNCE_TICKS == 1) begin
                state_d[i] = FIRE;
              end else begin
                state_d[i] = CONFIRM;
                cnt_d[i]   = CW'(1);
              end
            end
          end
          CONFIRM: begin
            if (!sync2_q[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
              state_d[i] = FIRE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          FIRE: begin
            state_d[i] = REFRACT;
            cnt_d[i]   = '0;
          end
          REFRACT: begin
            if (cnt_q[i] < REF_LIM) begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!sync2_q[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end
          end
        endcase
      end
      // Clear beats a simultaneous FIRE entry
      if (clear_counts) begin
        evt_d[i] = '0;
      end else if ((state_d[i] == FIRE) && (state_q[i] != FIRE) && (evt_q[i] != EVT_MAX)) begin
        evt_d[i] = evt_q[i] + CNT_W'(1);
      end
      event_d[i] = (state_d[i] == FIRE);
      busy_d[i]  = (state_d[i] == FIRE) || (state_d[i] == REFRACT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      event_q    <= '0;
      busy_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        evt_q[i]   <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      event_q    <= event_d;
      busy_q     <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        evt_q[i]   <= evt_d[i];
      end
    end
  end

  assign tick      = tick_c;
  assign event_out = event_q;
  assign busy      = busy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign event_cnt[g*CNT_W +: CNT_W] = evt_q[g];
  end

endmodule
